// File: rtl/ifetch_queue.sv
// In-order instruction fetch queue between the PC generator and decode.
// Issues one imem read per accepted PC, buffers responses, and drops wrong-path returns on redirect.
module ifetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        StallF,
  input  logic        PCSrcE,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        StallD,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // NOTE: pc/instr storage is not reset; the filled bits and count gate every read of it.
  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [AW-1:0] r_wr_ptr, r_fill_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;     // allocated entries (filled or not)
  logic [CW-1:0] r_pend;      // allocated but still waiting for their response
  logic [CW-1:0] r_drop_cnt;  // wrong-path responses still to be discarded

  logic w_full, w_accept, w_head_valid, w_pop, w_fill, w_drop, w_flush_rsp;

  assign w_full         = (r_count == CW'(DEPTH));
  assign imem_req_valid = !rst && !PCSrcE && !w_full;
  assign imem_req_addr  = PCF;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign StallF         = !w_accept;

  assign w_head_valid = (r_count != '0) && r_filled[r_rd_ptr];
  assign ValidD       = w_head_valid;
  assign InstrD       = w_head_valid ? r_instr[r_rd_ptr] : NOP;
  assign PCD          = w_head_valid ? r_pc[r_rd_ptr] : 32'd0;
  assign PCPlus4D     = w_head_valid ? r_pc[r_rd_ptr] + 32'd4 : 32'd0;

  assign w_pop  = w_head_valid && !StallD && !PCSrcE;
  assign w_drop = imem_rsp_valid && (r_drop_cnt != '0);
  // A response with nothing pending and nothing to drop is a protocol error and is ignored.
  assign w_fill = imem_rsp_valid && (r_drop_cnt == '0) && (r_pend != '0) && !PCSrcE;
  // Only a response that belongs to some request is subtracted during a flush.
  assign w_flush_rsp = imem_rsp_valid && ((r_drop_cnt != '0) || (r_pend != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop_cnt <= '0;
      r_filled   <= '0;
    end else if (PCSrcE) begin
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_filled   <= '0;
      r_drop_cnt <= r_drop_cnt + r_pend - CW'(w_flush_rsp);
    end else begin
      r_count <= r_count + CW'(w_accept) - CW'(w_pop);
      r_pend  <= r_pend + CW'(w_accept) - CW'(w_fill);
      if (w_accept) begin
        r_wr_ptr           <= r_wr_ptr + AW'(1);
        r_filled[r_wr_ptr] <= 1'b0;
      end
      if (w_fill) begin
        r_fill_ptr           <= r_fill_ptr + AW'(1);
        r_filled[r_fill_ptr] <= 1'b1;
      end
      if (w_pop)  r_rd_ptr   <= r_rd_ptr + AW'(1);
      if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pc[r_wr_ptr]      <= PCF;
    if (w_fill)   r_instr[r_fill_ptr] <= imem_rsp_data;
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((r_drop_cnt != '0) || (r_pend != '0)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: variable-latency in-order memory, a PC generator, and a
// queue-level reference model of the fetch buffer driven by directed and random phases.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        StallF;
  logic        PCSrcE;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        StallD;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  ifetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .StallF(StallF), .PCSrcE(PCSrcE),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .StallD(StallD), .ValidD(ValidD),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  ent_t  q[$];
  mreq_t mq[$];
  int    drop;
  logic [31:0] pc_f;
  int    cyc;
  int    lat;

  // stimulus knobs for the next cycle
  bit          t_rst, t_flush, t_stalld, t_ready;
  logic [31:0] t_target;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], 16'h0033} ^ 32'h5A5A_0000;
  endfunction

  task automatic step();
    bit          rsp, exp_rv, exp_acc, exp_v;
    logic [31:0] head_pc;
    int          unf;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    rst            = t_rst;
    PCSrcE         = t_flush;
    StallD         = t_stalld;
    imem_req_ready = t_ready;
    PCF            = pc_f;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word_of(mq[0].addr) : 32'hDEAD_BEEF;
    #2;
    exp_rv  = !t_rst && !t_flush && (q.size() < DEPTH);
    exp_acc = exp_rv && t_ready;
    exp_v   = (q.size() > 0) && q[0].filled;
    head_pc = (q.size() > 0) ? q[0].pc : 32'd0;
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check("stallf", 32'(StallF), 32'(!exp_acc));
    if (!t_rst) begin
      if (exp_rv) check("req_addr", imem_req_addr, pc_f);
      check("validd", 32'(ValidD), 32'(exp_v));
      check("instrd", InstrD, exp_v ? q[0].instr : NOP);
      check("pcd", PCD, exp_v ? head_pc : 32'd0);
      check("pcplus4d", PCPlus4D, exp_v ? head_pc + 32'd4 : 32'd0);
      check("count", 32'(dut.r_count), 32'(q.size()));
      check("drop_cnt", 32'(dut.r_drop_cnt), 32'(drop));
    end
    @(posedge clk);
    #1;
    if (t_rst) begin
      q.delete();
      mq.delete();
      drop = 0;
      pc_f = 32'd0;
    end else begin
      if (rsp) void'(mq.pop_front());
      if (t_flush) begin
        unf = 0;
        foreach (q[i]) if (!q[i].filled) unf++;
        drop = drop + unf - (rsp ? 1 : 0);
        q.delete();
        pc_f = t_target;
      end else begin
        if (rsp) begin
          if (drop > 0) drop--;
          else begin
            for (int i = 0; i < q.size(); i++) begin
              if (!q[i].filled) begin
                q[i].filled = 1'b1;
                q[i].instr  = imem_rsp_data;
                break;
              end
            end
          end
        end
        if (exp_v && !t_stalld) void'(q.pop_front());
        if (exp_acc) begin
          q.push_back('{pc: pc_f, instr: 32'd0, filled: 1'b0});
          mq.push_back('{addr: pc_f, due: cyc + lat});
          pc_f = pc_f + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    cyc = 0; drop = 0; pc_f = 32'd0; lat = 1;
    t_rst = 1'b1; t_flush = 1'b0; t_stalld = 1'b0; t_ready = 1'b1;
    t_target = 32'h0000_1000;

    // 1: reset then a steady single-cycle memory stream
    run(3);
    t_rst = 1'b0;
    run(12);

    // 2: decode stalled long enough to fill the queue, then drain
    t_stalld = 1'b1;
    run(6);
    t_stalld = 1'b0;
    run(8);

    // 3: long memory latency, redirect with responses in flight
    lat = 3;
    run(4);
    t_flush = 1'b1; t_target = 32'h0000_2000;
    run(1);
    t_flush = 1'b0;
    run(10);

    // 4: redirect while a response arrives and the head would pop
    lat = 1;
    run(6);
    t_flush = 1'b1; t_target = 32'h0000_3000;
    run(1);
    t_flush = 1'b1; t_target = 32'h0000_3400;
    run(1);
    t_flush = 1'b0;
    run(6);

    // 5: memory ready toggling
    for (int i = 0; i < 8; i++) begin
      t_ready = (i % 2) == 0;
      run(1);
    end
    t_ready = 1'b1;
    run(6);

    // 6: reset in the middle of buffered traffic
    t_stalld = 1'b1;
    run(3);
    t_rst = 1'b1;
    run(1);
    t_rst = 1'b0; t_stalld = 1'b0;
    run(8);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      t_ready  = $urandom_range(0, 3) != 0;
      t_stalld = $urandom_range(0, 3) == 0;
      t_flush  = $urandom_range(0, 19) == 0;
      t_rst    = $urandom_range(0, 299) == 0;
      t_target = $urandom() & 32'hFFFF_FFFC;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
